// File: rtl/deserializer_align.sv
// Receive-side deserializer for the 10-bit 8b/10b link: shifts serial bits in MSB first,
// finds the word boundary from K28.5 commas, and emits aligned words with a valid strobe.
module deserializer_align #(
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 4,
    parameter logic [9:0] COMMA_P    = 10'b0011111010,
    parameter logic [9:0] COMMA_N    = 10'b1100000101
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic       si,
    output logic [9:0] dout,
    output logic       dout_valid,
    output logic       is_comma,
    output logic       locked,
    output logic       align_err
);

    localparam int OK_W  = $clog2(LOCK_CNT + 1);
    localparam int ERR_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [OK_W-1:0]  OK_LAST  = OK_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state, state_next;
    logic [9:0]       sr;
    logic [3:0]       bit_cnt, bit_cnt_next;
    logic [OK_W-1:0]  ok_cnt, ok_next;
    logic [ERR_W-1:0] err_cnt, err_next;
    logic             hit, boundary, rephase, misaligned;

    assign hit      = (sr == COMMA_P) || (sr == COMMA_N);
    assign boundary = (bit_cnt == 4'd9);

    // A re-phase makes the current hit cycle the boundary, so the next one is 10 cycles out.
    always_comb begin
        state_next   = state;
        ok_next      = ok_cnt;
        err_next     = err_cnt;
        rephase      = 1'b0;
        misaligned   = 1'b0;
        case (state)
            HUNT: begin
                if (hit) begin
                    rephase = 1'b1;
                    ok_next = OK_W'(1);
                    if (LOCK_CNT == 1) begin
                        state_next = LOCKED;
                        err_next   = '0;
                    end else begin
                        state_next = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (hit && boundary) begin
                    ok_next = ok_cnt + OK_W'(1);
                    if (ok_cnt == OK_LAST) begin
                        state_next = LOCKED;
                        err_next   = '0;
                    end
                end else if (hit) begin
                    rephase = 1'b1;
                    ok_next = OK_W'(1);
                end
            end
            LOCKED: begin
                if (hit && boundary) begin
                    err_next = '0;
                end else if (hit) begin
                    misaligned = 1'b1;
                    err_next   = err_cnt + ERR_W'(1);
                    if (err_cnt == ERR_LAST) begin
                        state_next = HUNT;
                        ok_next    = '0;
                    end
                end
            end
            default: state_next = HUNT;
        endcase
        if (rephase || boundary) begin
            bit_cnt_next = 4'd0;
        end else begin
            bit_cnt_next = bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            ok_cnt     <= '0;
            err_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            is_comma   <= 1'b0;
            locked     <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= {sr[8:0], si};
            bit_cnt   <= bit_cnt_next;
            ok_cnt    <= ok_next;
            err_cnt   <= err_next;
            locked    <= (state == LOCKED);
            align_err <= misaligned;
            if ((state == LOCKED) && boundary) begin
                dout       <= sr;
                dout_valid <= 1'b1;
                is_comma   <= hit;
            end else begin
                dout_valid <= 1'b0;
                is_comma   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_align.sv
// Directed bench for deserializer_align: reset, acquisition, disparity, slip, VERIFY restart
// and reset-while-locked, with strobes logged by a monitor and checked against hand values.
module tb_deserializer_align;

    localparam logic [9:0] COMMA_P = 10'b0011111010;
    localparam logic [9:0] COMMA_N = 10'b1100000101;
    localparam logic [9:0] WORD_A  = 10'h2AA;
    localparam logic [9:0] WORD_B  = 10'h155;

    logic       fclk  = 1'b0;
    logic       reset = 1'b1;
    logic       si    = 1'b0;
    logic [9:0] dout;
    logic       dout_valid, is_comma, locked, align_err;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  word;
        logic        comma;
    } strobe_t;

    strobe_t strobes[$];
    int      cyc          = 0;
    int      err_pulses   = 0;
    int      tests_run    = 0;
    int      tests_failed = 0;

    deserializer_align dut (
        .fclk      (fclk),
        .reset     (reset),
        .si        (si),
        .dout      (dout),
        .dout_valid(dout_valid),
        .is_comma  (is_comma),
        .locked    (locked),
        .align_err (align_err)
    );

    always #5 fclk = ~fclk;

    // Log every strobe and error pulse just after the edge that produced it.
    always @(posedge fclk) begin
        strobe_t s;
        #1;
        cyc++;
        if (dout_valid === 1'b1) begin
            s.cyc   = 32'(cyc);
            s.word  = dout;
            s.comma = is_comma;
            strobes.push_back(s);
        end
        if (align_err === 1'b1) err_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] word, input int nbits = 10);
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge fclk);
            si = word[i];
        end
    endtask

    task automatic checkStrobe(input string tag, input int idx, input logic [9:0] word,
                               input logic comma);
        checkOutput({tag, "_present"}, 32'(idx < strobes.size()), 32'd1);
        if (idx < strobes.size()) begin
            checkOutput({tag, "_dout"}, 32'(strobes[idx].word), 32'(word));
            checkOutput({tag, "_comma"}, 32'(strobes[idx].comma), 32'(comma));
            if (idx > 0)
                checkOutput({tag, "_gap"}, strobes[idx].cyc - strobes[idx-1].cyc, 32'd10);
        end
    endtask

    task automatic acquireAndCheck(input string tag);
        int base;
        base = strobes.size();
        applyStimulus(10'b1010000000, 3);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        checkOutput({tag, "_unlocked_pre"}, 32'(locked), 32'd0);
        applyStimulus(WORD_A);
        checkOutput({tag, "_locked"}, 32'(locked), 32'd1);
        applyStimulus(WORD_B);
        applyStimulus(WORD_A);
        applyStimulus(WORD_B);
        checkOutput({tag, "_first_word"}, 32'(strobes.size() > base), 32'd1);
        if (strobes.size() > base)
            checkOutput({tag, "_first_dout"}, 32'(strobes[base].word), 32'(WORD_A));
        checkStrobe({tag, "_s1"}, base + 1, WORD_B, 1'b0);
        checkStrobe({tag, "_s2"}, base + 2, WORD_A, 1'b0);
    endtask

    initial begin
        int base;
        int e0;

        for (int i = 0; i < 5; i++) begin
            @(negedge fclk);
            checkOutput("reset_hold", 32'({dout, dout_valid, is_comma, locked, align_err}), 32'd0);
            si = ~si;
        end
        reset = 1'b0;
        si    = 1'b0;

        acquireAndCheck("acq");

        e0 = err_pulses;
        applyStimulus(COMMA_P);
        base = strobes.size();
        applyStimulus(COMMA_N);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_N);
        applyStimulus(WORD_A);
        applyStimulus(WORD_B);
        checkStrobe("disp0", base,     COMMA_P, 1'b1);
        checkStrobe("disp1", base + 1, COMMA_N, 1'b1);
        checkStrobe("disp2", base + 2, COMMA_P, 1'b1);
        checkStrobe("disp3", base + 3, COMMA_N, 1'b1);
        checkOutput("disp_no_err", 32'(err_pulses - e0), 32'd0);

        // One dropped bit puts every following comma one cycle ahead of the boundary.
        e0 = err_pulses;
        applyStimulus(WORD_A, 9);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        checkOutput("slip_err1", 32'(err_pulses - e0), 32'd1);
        checkOutput("slip_lock1", 32'(locked), 32'd1);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        checkOutput("slip_err3", 32'(err_pulses - e0), 32'd3);
        checkOutput("slip_lock3", 32'(locked), 32'd1);
        applyStimulus(COMMA_P);
        checkOutput("slip_err4", 32'(err_pulses - e0), 32'd4);
        checkOutput("slip_unlock", 32'(locked), 32'd0);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        checkOutput("slip_relock_pre", 32'(locked), 32'd0);
        applyStimulus(WORD_A);
        checkOutput("slip_relock", 32'(locked), 32'd1);
        checkOutput("slip_err_final", 32'(err_pulses - e0), 32'd4);

        @(negedge fclk);
        reset = 1'b1;
        @(negedge fclk);
        reset = 1'b0;
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        applyStimulus(10'b1010000000, 4);
        applyStimulus(COMMA_P);
        applyStimulus(COMMA_P);
        applyStimulus(WORD_A);
        checkOutput("restart_nolock", 32'(locked), 32'd0);
        applyStimulus(COMMA_P);
        applyStimulus(WORD_A);
        checkOutput("restart_lock", 32'(locked), 32'd1);

        applyStimulus(WORD_B, 5);
        @(negedge fclk);
        reset = 1'b1;
        @(negedge fclk);
        checkOutput("midrst_locked", 32'(locked), 32'd0);
        checkOutput("midrst_valid", 32'(dout_valid), 32'd0);
        checkOutput("midrst_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        acquireAndCheck("reacq");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
